// File: rtl/riscv_uop_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_uop_pkg
// Description : Micro-op side-band record carried unchanged from issue to
//               retire through the execute stage.
// Revision    : 1.0  initial release
// ============================================================================
package riscv_uop_pkg;

  // Opaque to the ALU: the execute unit only registers it alongside the
  // result so retire sees the record that belongs to each result.
  typedef struct packed {
    logic [31:0] insn;     // raw instruction word
    logic [7:0]  rob_tag;  // reorder / retire tag
  } uop_t;

endpackage : riscv_uop_pkg
`default_nettype wire

// File: rtl/rv_alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module      : rv_alu_exec_unit
// Description : Single-cycle RV32I integer execute stage. Computes the ALU
//               result for one resolved micro-op per cycle, drives a
//               same-cycle bypass to issue and registers the result toward
//               retire. Hold on stall, kill on flush (flush wins).
// Revision    : 1.0  initial release
// ============================================================================
module rv_alu_exec_unit
  import riscv_uop_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,              // synchronous, active-high
  // issue side
  input  logic        i_issue_valid,
  input  logic [3:0]  i_issue_alu_op,
  input  logic [31:0] i_issue_op_a,
  input  logic [31:0] i_issue_op_b,
  input  logic [31:0] i_issue_pc,
  input  logic [4:0]  i_issue_rd,
  input  logic        i_issue_writes_rd,
  input  uop_t        i_issue_uop,
  output logic        o_issue_ready,
  // pipeline control
  input  logic        i_stall,
  input  logic        i_flush,
  // same-cycle bypass
  output logic        o_alu_fwd_writes_rd,
  output logic [4:0]  o_alu_fwd_rd,
  output logic [31:0] o_alu_fwd_result,
  // registered result toward retire
  output logic        o_valid,
  output logic [31:0] o_alu_result,
  output uop_t        o_uop_forward
);

  // --------------------------------------------------------------------------
  // Operation encoding
  // --------------------------------------------------------------------------
  localparam logic [3:0] C_OP_ADD    = 4'd0;
  localparam logic [3:0] C_OP_SUB    = 4'd1;
  localparam logic [3:0] C_OP_SLL    = 4'd2;
  localparam logic [3:0] C_OP_SLT    = 4'd3;
  localparam logic [3:0] C_OP_SLTU   = 4'd4;
  localparam logic [3:0] C_OP_XOR    = 4'd5;
  localparam logic [3:0] C_OP_SRL    = 4'd6;
  localparam logic [3:0] C_OP_SRA    = 4'd7;
  localparam logic [3:0] C_OP_OR     = 4'd8;
  localparam logic [3:0] C_OP_AND    = 4'd9;
  localparam logic [3:0] C_OP_PASS_B = 4'd10;
  localparam logic [3:0] C_OP_PC_ADD = 4'd11;
  localparam logic [3:0] C_OP_LINK   = 4'd12;

  localparam logic [31:0] C_LINK_OFFSET = 32'd4;

  // --------------------------------------------------------------------------
  // Combinational datapath
  // --------------------------------------------------------------------------
  logic [4:0]  w_shamt;
  logic [31:0] w_sum;
  logic [31:0] w_diff;
  logic [31:0] w_pc_sum;
  logic [31:0] w_link;
  logic        w_lt_signed;
  logic        w_lt_unsigned;
  logic [31:0] w_result;
  logic        w_accept;

  // Only the low five bits of b take part in shifts; upper bits are ignored.
  assign w_shamt       = i_issue_op_b[4:0];
  assign w_sum         = i_issue_op_a + i_issue_op_b;
  assign w_diff        = i_issue_op_a - i_issue_op_b;
  assign w_pc_sum      = i_issue_pc + i_issue_op_b;
  assign w_link        = i_issue_pc + C_LINK_OFFSET;
  assign w_lt_signed   = $signed(i_issue_op_a) < $signed(i_issue_op_b);
  assign w_lt_unsigned = i_issue_op_a < i_issue_op_b;

  // Result mux; unassigned opcodes (13-15) yield zero.
  always_comb begin
    w_result = 32'd0;
    case (i_issue_alu_op)
      C_OP_ADD:    w_result = w_sum;
      C_OP_SUB:    w_result = w_diff;
      C_OP_SLL:    w_result = i_issue_op_a << w_shamt;
      C_OP_SLT:    w_result = {31'd0, w_lt_signed};
      C_OP_SLTU:   w_result = {31'd0, w_lt_unsigned};
      C_OP_XOR:    w_result = i_issue_op_a ^ i_issue_op_b;
      C_OP_SRL:    w_result = i_issue_op_a >> w_shamt;
      C_OP_SRA:    w_result = $unsigned($signed(i_issue_op_a) >>> w_shamt);
      C_OP_OR:     w_result = i_issue_op_a | i_issue_op_b;
      C_OP_AND:    w_result = i_issue_op_a & i_issue_op_b;
      C_OP_PASS_B: w_result = i_issue_op_b;
      C_OP_PC_ADD: w_result = w_pc_sum;
      C_OP_LINK:   w_result = w_link;
      default:     w_result = 32'd0;
    endcase
  end

  // --------------------------------------------------------------------------
  // Handshake and bypass
  // --------------------------------------------------------------------------
  // A flushed op is still consumed (ready stays high) but never retires.
  assign o_issue_ready = !i_stall;
  assign w_accept      = o_issue_ready & i_issue_valid & !i_flush;

  // x0 is never forwarded; a flushed op must not feed younger consumers.
  assign o_alu_fwd_writes_rd = i_issue_valid & i_issue_writes_rd &
                               (i_issue_rd != 5'd0) & !i_flush;
  assign o_alu_fwd_rd        = i_issue_rd;
  assign o_alu_fwd_result    = w_result;

  // --------------------------------------------------------------------------
  // Output register
  // --------------------------------------------------------------------------
  logic        r_valid;
  logic [31:0] r_result;
  uop_t        r_uop;

  // Valid bit: reset > flush > stall-hold > follow issue_valid.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_valid <= 1'b0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (!i_stall) begin
      r_valid <= i_issue_valid;
    end
  end

  // Payload only loads on accept; otherwise it keeps its last value.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_result <= 32'd0;
      r_uop    <= '0;
    end else if (w_accept) begin
      r_result <= w_result;
      r_uop    <= i_issue_uop;
    end
  end

  assign o_valid       = r_valid;
  assign o_alu_result  = r_result;
  assign o_uop_forward = r_uop;

endmodule : rv_alu_exec_unit
`default_nettype wire

// File: tb/tb_rv_alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_rv_alu_exec_unit
// Description : Directed self-checking bench for rv_alu_exec_unit.
// Revision    : 1.0  initial release
// ============================================================================
module tb_rv_alu_exec_unit;
  import riscv_uop_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        i_issue_valid;
  logic [3:0]  i_issue_alu_op;
  logic [31:0] i_issue_op_a;
  logic [31:0] i_issue_op_b;
  logic [31:0] i_issue_pc;
  logic [4:0]  i_issue_rd;
  logic        i_issue_writes_rd;
  uop_t        i_issue_uop;
  logic        o_issue_ready;
  logic        i_stall;
  logic        i_flush;
  logic        o_alu_fwd_writes_rd;
  logic [4:0]  o_alu_fwd_rd;
  logic [31:0] o_alu_fwd_result;
  logic        o_valid;
  logic [31:0] o_alu_result;
  uop_t        o_uop_forward;

  int checks;
  int failures;

  rv_alu_exec_unit dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .i_issue_valid       (i_issue_valid),
    .i_issue_alu_op      (i_issue_alu_op),
    .i_issue_op_a        (i_issue_op_a),
    .i_issue_op_b        (i_issue_op_b),
    .i_issue_pc          (i_issue_pc),
    .i_issue_rd          (i_issue_rd),
    .i_issue_writes_rd   (i_issue_writes_rd),
    .i_issue_uop         (i_issue_uop),
    .o_issue_ready       (o_issue_ready),
    .i_stall             (i_stall),
    .i_flush             (i_flush),
    .o_alu_fwd_writes_rd (o_alu_fwd_writes_rd),
    .o_alu_fwd_rd        (o_alu_fwd_rd),
    .o_alu_fwd_result    (o_alu_fwd_result),
    .o_valid             (o_valid),
    .o_alu_result        (o_alu_result),
    .o_uop_forward       (o_uop_forward)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one active edge and settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one op on the issue inputs.
  task automatic issue(input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] pc,
                       input logic [4:0] rd, input logic wr);
    i_issue_valid     = 1'b1;
    i_issue_alu_op    = op;
    i_issue_op_a      = a;
    i_issue_op_b      = b;
    i_issue_pc        = pc;
    i_issue_rd        = rd;
    i_issue_writes_rd = wr;
    #1;
  endtask

  task automatic test_reset();
    rst_n       = 1'b1;
    i_stall     = 1'b0;
    i_flush     = 1'b0;
    i_issue_uop = '{insn: 32'h00700293, rob_tag: 8'h5A};
    issue(4'd0, 32'd5, 32'd7, 32'h0, 5'd1, 1'b1);
    tick();
    tick();
    checks++;
    if (o_valid !== 1'b0) begin
      failures++; $display("FAIL reset_valid got=%b want=0", o_valid);
    end
    checks++;
    if (o_alu_result !== 32'd0) begin
      failures++; $display("FAIL reset_result got=%h want=0", o_alu_result);
    end
    checks++;
    if (o_uop_forward !== 40'd0) begin
      failures++; $display("FAIL reset_uop got=%h want=0", o_uop_forward);
    end
    rst_n = 1'b0;
    tick();
    checks++;
    if (o_valid !== 1'b1 || o_alu_result !== 32'd12) begin
      failures++;
      $display("FAIL first_add got=%b/%0d want=1/12", o_valid, o_alu_result);
    end
    checks++;
    if (o_uop_forward !== 40'h00700293_5A) begin
      failures++; $display("FAIL uop_pass got=%h want=007002935a", o_uop_forward);
    end
  endtask

  // Arithmetic, compare, logic, shift and PC vectors; one op per cycle.
  task automatic test_alu_ops();
    logic [3:0]  op  [17];
    logic [31:0] a   [17];
    logic [31:0] b   [17];
    logic [31:0] pc  [17];
    logic [31:0] exp [17];
    op[0]  = 4'd1;  a[0]  = 32'h0;        b[0]  = 32'h1;        pc[0]  = 0;        exp[0]  = 32'hFFFFFFFF;
    op[1]  = 4'd3;  a[1]  = 32'hFFFFFFFF; b[1]  = 32'h1;        pc[1]  = 0;        exp[1]  = 32'h1;
    op[2]  = 4'd4;  a[2]  = 32'hFFFFFFFF; b[2]  = 32'h1;        pc[2]  = 0;        exp[2]  = 32'h0;
    op[3]  = 4'd0;  a[3]  = 32'hFFFFFFFF; b[3]  = 32'h1;        pc[3]  = 0;        exp[3]  = 32'h0;
    op[4]  = 4'd7;  a[4]  = 32'h80000000; b[4]  = 32'h24;       pc[4]  = 0;        exp[4]  = 32'hF8000000;
    op[5]  = 4'd6;  a[5]  = 32'h80000000; b[5]  = 32'h24;       pc[5]  = 0;        exp[5]  = 32'h08000000;
    op[6]  = 4'd2;  a[6]  = 32'h1;        b[6]  = 32'd31;       pc[6]  = 0;        exp[6]  = 32'h80000000;
    op[7]  = 4'd12; a[7]  = 32'h55;       b[7]  = 32'h77;       pc[7]  = 32'h100;  exp[7]  = 32'h104;
    op[8]  = 4'd11; a[8]  = 32'h55;       b[8]  = 32'h1000;     pc[8]  = 32'h100;  exp[8]  = 32'h1100;
    op[9]  = 4'd10; a[9]  = 32'h55;       b[9]  = 32'hABCDE000; pc[9]  = 32'h100;  exp[9]  = 32'hABCDE000;
    op[10] = 4'd5;  a[10] = 32'hF0F0F0F0; b[10] = 32'hFF00FF00; pc[10] = 0;        exp[10] = 32'h0FF00FF0;
    op[11] = 4'd8;  a[11] = 32'hF0F0F0F0; b[11] = 32'h0F000F00; pc[11] = 0;        exp[11] = 32'hFFF0FFF0;
    op[12] = 4'd9;  a[12] = 32'hF0F0F0F0; b[12] = 32'hFF00FF00; pc[12] = 0;        exp[12] = 32'hF000F000;
    op[13] = 4'd13; a[13] = 32'h12345678; b[13] = 32'h1;        pc[13] = 32'h40;   exp[13] = 32'h0;
    op[14] = 4'd3;  a[14] = 32'h1;        b[14] = 32'hFFFFFFFF; pc[14] = 0;        exp[14] = 32'h0;
    op[15] = 4'd4;  a[15] = 32'h1;        b[15] = 32'hFFFFFFFF; pc[15] = 0;        exp[15] = 32'h1;
    op[16] = 4'd15; a[16] = 32'hFFFFFFFF; b[16] = 32'hFFFFFFFF; pc[16] = 32'hFFC;  exp[16] = 32'h0;
    for (int i = 0; i < 17; i++) begin
      issue(op[i], a[i], b[i], pc[i], 5'd3, 1'b1);
      checks++;
      if (o_alu_fwd_result !== exp[i]) begin
        failures++;
        $display("FAIL alu_fwd[%0d] op=%0d got=%h want=%h", i, op[i], o_alu_fwd_result, exp[i]);
      end
      tick();
      checks++;
      if (o_valid !== 1'b1 || o_alu_result !== exp[i]) begin
        failures++;
        $display("FAIL alu_reg[%0d] op=%0d got=%b/%h want=1/%h", i, op[i], o_valid, o_alu_result, exp[i]);
      end
    end
  endtask

  task automatic test_bypass();
    issue(4'd0, 32'd3, 32'd4, 32'h0, 5'd5, 1'b1);
    checks++;
    if (o_alu_fwd_writes_rd !== 1'b1 || o_alu_fwd_rd !== 5'd5 || o_alu_fwd_result !== 32'd7) begin
      failures++;
      $display("FAIL bypass_rd5 got=%b/%0d/%0d want=1/5/7", o_alu_fwd_writes_rd, o_alu_fwd_rd, o_alu_fwd_result);
    end
    issue(4'd0, 32'd3, 32'd4, 32'h0, 5'd0, 1'b1);
    checks++;
    if (o_alu_fwd_writes_rd !== 1'b0) begin
      failures++; $display("FAIL bypass_x0 got=%b want=0", o_alu_fwd_writes_rd);
    end
    issue(4'd0, 32'd3, 32'd4, 32'h0, 5'd9, 1'b0);
    checks++;
    if (o_alu_fwd_writes_rd !== 1'b0) begin
      failures++; $display("FAIL bypass_nowr got=%b want=0", o_alu_fwd_writes_rd);
    end
    issue(4'd0, 32'd3, 32'd4, 32'h0, 5'd9, 1'b1);
    i_issue_valid = 1'b0;
    #1;
    checks++;
    if (o_alu_fwd_writes_rd !== 1'b0) begin
      failures++; $display("FAIL bypass_invalid got=%b want=0", o_alu_fwd_writes_rd);
    end
    // Idle cycle: nothing retires next edge.
    tick();
    checks++;
    if (o_valid !== 1'b0) begin
      failures++; $display("FAIL idle_valid got=%b want=0", o_valid);
    end
  endtask

  task automatic test_stall_flush();
    i_issue_uop = '{insn: 32'h11111111, rob_tag: 8'h01};
    issue(4'd0, 32'd5, 32'd7, 32'h0, 5'd4, 1'b1);
    tick();
    checks++;
    if (o_valid !== 1'b1 || o_alu_result !== 32'd12) begin
      failures++; $display("FAIL pre_stall got=%b/%0d want=1/12", o_valid, o_alu_result);
    end
    i_issue_uop = '{insn: 32'h22222222, rob_tag: 8'h02};
    issue(4'd1, 32'd100, 32'd1, 32'h0, 5'd6, 1'b1);
    i_stall = 1'b1;
    #1;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (o_issue_ready !== 1'b0) begin
        failures++; $display("FAIL stall_ready[%0d] got=%b want=0", c, o_issue_ready);
      end
      checks++;
      if (o_alu_fwd_writes_rd !== 1'b1 || o_alu_fwd_result !== 32'd99) begin
        failures++;
        $display("FAIL stall_fwd[%0d] got=%b/%0d want=1/99", c, o_alu_fwd_writes_rd, o_alu_fwd_result);
      end
      tick();
      checks++;
      if (o_valid !== 1'b1 || o_alu_result !== 32'd12 || o_uop_forward !== 40'h11111111_01) begin
        failures++;
        $display("FAIL stall_hold[%0d] got=%b/%0d/%h want=1/12/1111111101", c, o_valid, o_alu_result, o_uop_forward);
      end
    end
    i_flush = 1'b1;
    #1;
    checks++;
    if (o_alu_fwd_writes_rd !== 1'b0) begin
      failures++; $display("FAIL flush_fwd got=%b want=0", o_alu_fwd_writes_rd);
    end
    tick();
    checks++;
    if (o_valid !== 1'b0) begin
      failures++; $display("FAIL flush_stall_valid got=%b want=0", o_valid);
    end
    // Flush without stall: op consumed (ready high) but dropped.
    i_stall = 1'b0;
    #1;
    checks++;
    if (o_issue_ready !== 1'b1) begin
      failures++; $display("FAIL flush_ready got=%b want=1", o_issue_ready);
    end
    tick();
    checks++;
    if (o_valid !== 1'b0) begin
      failures++; $display("FAIL flush_valid got=%b want=0", o_valid);
    end
    i_flush = 1'b0;
  endtask

  task automatic test_back_to_back();
    issue(4'd0, 32'd10, 32'd20, 32'h0, 5'd1, 1'b1);
    tick();
    checks++;
    if (o_valid !== 1'b1 || o_alu_result !== 32'd30) begin
      failures++; $display("FAIL b2b_0 got=%b/%0d want=1/30", o_valid, o_alu_result);
    end
    issue(4'd1, 32'd10, 32'd20, 32'h0, 5'd2, 1'b1);
    tick();
    checks++;
    if (o_valid !== 1'b1 || o_alu_result !== 32'hFFFFFFF6) begin
      failures++; $display("FAIL b2b_1 got=%b/%h want=1/fffffff6", o_valid, o_alu_result);
    end
    // Reset mid-stream discards the in-flight op.
    issue(4'd8, 32'h0F, 32'hF0, 32'h0, 5'd3, 1'b1);
    rst_n = 1'b1;
    tick();
    checks++;
    if (o_valid !== 1'b0 || o_alu_result !== 32'd0) begin
      failures++; $display("FAIL midreset got=%b/%h want=0/0", o_valid, o_alu_result);
    end
    rst_n = 1'b0;
    tick();
    checks++;
    if (o_valid !== 1'b1 || o_alu_result !== 32'hFF) begin
      failures++; $display("FAIL post_reset got=%b/%h want=1/ff", o_valid, o_alu_result);
    end
    i_issue_valid = 1'b0;
    tick();
    checks++;
    if (o_valid !== 1'b0 || o_alu_result !== 32'hFF) begin
      failures++; $display("FAIL drain got=%b/%h want=0/ff", o_valid, o_alu_result);
    end
  endtask

  initial begin
    checks            = 0;
    failures          = 0;
    rst_n             = 1'b1;
    i_issue_valid     = 1'b0;
    i_issue_alu_op    = 4'd0;
    i_issue_op_a      = 32'd0;
    i_issue_op_b      = 32'd0;
    i_issue_pc        = 32'd0;
    i_issue_rd        = 5'd0;
    i_issue_writes_rd = 1'b0;
    i_issue_uop       = '0;
    i_stall           = 1'b0;
    i_flush           = 1'b0;
    test_reset();
    test_alu_ops();
    test_bypass();
    test_stall_flush();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_rv_alu_exec_unit
`default_nettype wire
